// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter in front of the register-bus chain head; one transaction in flight.
// Optional response timeout (err_o abort) is compiled in when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] r0_addr_i,
    input  logic [DATA_WIDTH-1:0] r0_wdata_i,
    input  logic                  r0_rw_i,
    input  logic                  r0_valid_i,
    output logic                  r0_busy_o,
    output logic [DATA_WIDTH-1:0] r0_rdata_o,
    output logic                  r0_rw_o,
    output logic                  r0_valid_o,
    output logic                  r0_err_o,
    input  logic [ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [DATA_WIDTH-1:0] r1_wdata_i,
    input  logic                  r1_rw_i,
    input  logic                  r1_valid_i,
    output logic                  r1_busy_o,
    output logic [DATA_WIDTH-1:0] r1_rdata_o,
    output logic                  r1_rw_o,
    output logic                  r1_valid_o,
    output logic                  r1_err_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic [DATA_WIDTH-1:0] ret_rdata_i,
    input  logic                  ret_rw_i,
    input  logic                  ret_valid_i
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state, state_next;

    logic pend0, pend1;
    logic owner, last;
    logic grant, issue, finish, expire, timeout_hit;
    logic take0, take1;

    logic [ADDR_WIDTH-1:0] hold0_addr, hold1_addr;
    logic [DATA_WIDTH-1:0] hold0_wdata, hold1_wdata;
    logic                  hold0_rw, hold1_rw;

    assign r0_busy_o = pend0 | ((state == ST_WAIT) && !owner);
    assign r1_busy_o = pend1 | ((state == ST_WAIT) && owner);

    assign take0 = r0_valid_i && !r0_busy_o;
    assign take1 = r1_valid_i && !r1_busy_o;

    // NOTE: holding registers have no reset; they are only read while their pend bit is set.
    always_ff @(posedge clk) begin
        if (take0) begin
            hold0_addr  <= r0_addr_i;
            hold0_wdata <= r0_wdata_i;
            hold0_rw    <= r0_rw_i;
        end
        if (take1) begin
            hold1_addr  <= r1_addr_i;
            hold1_wdata <= r1_wdata_i;
            hold1_rw    <= r1_rw_i;
        end
    end

    // A capture and the owner's completion never coincide: busy blocks the capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            if (take0)
                pend0 <= 1'b1;
            else if (finish && !owner)
                pend0 <= 1'b0;
            if (take1)
                pend1 <= 1'b1;
            else if (finish && owner)
                pend1 <= 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        finish     = 1'b0;
        expire     = 1'b0;
        // On a tie the requester that did not complete last wins.
        grant      = pend1 & (~pend0 | ~last);
        case (state)
            ST_IDLE: begin
                if (pend0 || pend1) begin
                    issue      = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ret_valid_i) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    finish     = 1'b1;
                    expire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last       <= 1'b1;
            addr_o     <= '0;
            wdata_o    <= '0;
            rw_o       <= 1'b0;
            valid_o    <= 1'b0;
            r0_rdata_o <= '0;
            r0_rw_o    <= 1'b0;
            r0_valid_o <= 1'b0;
            r1_rdata_o <= '0;
            r1_rw_o    <= 1'b0;
            r1_valid_o <= 1'b0;
        end else begin
            valid_o    <= 1'b0;
            r0_valid_o <= 1'b0;
            r1_valid_o <= 1'b0;
            if (issue) begin
                owner   <= grant;
                valid_o <= 1'b1;
                addr_o  <= grant ? hold1_addr  : hold0_addr;
                wdata_o <= grant ? hold1_wdata : hold0_wdata;
                rw_o    <= grant ? hold1_rw    : hold0_rw;
            end
            if (finish) begin
                last <= owner;
                // An aborted transaction returns zero data and the direction that was issued.
                if (owner) begin
                    r1_valid_o <= 1'b1;
                    r1_rdata_o <= expire ? '0 : ret_rdata_i;
                    r1_rw_o    <= expire ? rw_o : ret_rw_i;
                end else begin
                    r0_valid_o <= 1'b1;
                    r0_rdata_o <= expire ? '0 : ret_rdata_i;
                    r0_rw_o    <= expire ? rw_o : ret_rw_i;
                end
            end
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;

    // Expiry fires on the TIMEOUT_CYCLES-th WAIT cycle without a response.
    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (issue)
            wait_cnt <= '0;
        else if (state == ST_WAIT)
            wait_cnt <= wait_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_err_o <= 1'b0;
            r1_err_o <= 1'b0;
        end else if (finish) begin
            if (owner)
                r1_err_o <= expire;
            else
                r0_err_o <= expire;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign r0_err_o       = 1'b0;
    assign r1_err_o       = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: capture, round-robin, writes, drops, timeout, reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] r0_addr_i = '0, r1_addr_i = '0;
    logic [15:0] r0_wdata_i = '0, r1_wdata_i = '0;
    logic        r0_rw_i = 1'b0, r1_rw_i = 1'b0;
    logic        r0_valid_i = 1'b0, r1_valid_i = 1'b0;
    logic        r0_busy_o, r1_busy_o;
    logic [15:0] r0_rdata_o, r1_rdata_o;
    logic        r0_rw_o, r1_rw_o;
    logic        r0_valid_o, r1_valid_o;
    logic        r0_err_o, r1_err_o;
    logic [15:0] addr_o, wdata_o;
    logic        rw_o, valid_o;
    logic [15:0] ret_rdata_i = '0;
    logic        ret_rw_i = 1'b0;
    logic        ret_valid_i = 1'b0;

    int passed = 0;
    int total  = 0;

    bus_arbiter #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r0_addr_i  (r0_addr_i),
        .r0_wdata_i (r0_wdata_i),
        .r0_rw_i    (r0_rw_i),
        .r0_valid_i (r0_valid_i),
        .r0_busy_o  (r0_busy_o),
        .r0_rdata_o (r0_rdata_o),
        .r0_rw_o    (r0_rw_o),
        .r0_valid_o (r0_valid_o),
        .r0_err_o   (r0_err_o),
        .r1_addr_i  (r1_addr_i),
        .r1_wdata_i (r1_wdata_i),
        .r1_rw_i    (r1_rw_i),
        .r1_valid_i (r1_valid_i),
        .r1_busy_o  (r1_busy_o),
        .r1_rdata_o (r1_rdata_o),
        .r1_rw_o    (r1_rw_o),
        .r1_valid_o (r1_valid_o),
        .r1_err_o   (r1_err_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .rw_o       (rw_o),
        .valid_o    (valid_o),
        .ret_rdata_i(ret_rdata_i),
        .ret_rw_i   (ret_rw_i),
        .ret_valid_i(ret_valid_i)
    );

    always #5 clk = ~clk;

    function automatic logic [73:0] all_outputs();
        return {valid_o, addr_o, wdata_o, rw_o,
                r0_valid_o, r0_rdata_o, r0_rw_o, r0_err_o, r0_busy_o,
                r1_valid_o, r1_rdata_o, r1_rw_o, r1_err_o, r1_busy_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        r0_valid_i = 1'b0; r1_valid_i = 1'b0; ret_valid_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input bit n, input logic [15:0] a, input logic [15:0] d, input logic rw);
        if (n) begin
            r1_addr_i = a; r1_wdata_i = d; r1_rw_i = rw; r1_valid_i = 1'b1;
        end else begin
            r0_addr_i = a; r0_wdata_i = d; r0_rw_i = rw; r0_valid_i = 1'b1;
        end
    endtask

    task automatic strobe();
        tick();
        r0_valid_i = 1'b0;
        r1_valid_i = 1'b0;
    endtask

    task automatic respond(input logic [15:0] d, input logic rw);
        ret_rdata_i = d; ret_rw_i = rw; ret_valid_i = 1'b1;
        tick();
        ret_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++; if (all_outputs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outputs()); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (all_outputs() !== '0) $display("FAIL after_reset_idle: got %h want 0", all_outputs()); else passed++;
    endtask

    task automatic test_single_read();
        set_req(0, 16'h0005, 16'h0000, 1'b0);
        strobe();
        total++; if ({r0_busy_o, r1_busy_o, valid_o} !== 3'b100) $display("FAIL rd_capture: got %b want 100", {r0_busy_o, r1_busy_o, valid_o}); else passed++;
        tick();
        total++; if ({valid_o, addr_o, rw_o} !== {1'b1, 16'h0005, 1'b0}) $display("FAIL rd_issue: got %b/%h/%b want 1/0005/0", valid_o, addr_o, rw_o); else passed++;
        tick();
        total++; if (valid_o !== 1'b0) $display("FAIL rd_issue_pulse: got %b want 0", valid_o); else passed++;
        respond(16'hA5A5, 1'b0);
        total++; if ({r0_valid_o, r0_rdata_o, r0_rw_o, r0_err_o, r0_busy_o} !== {1'b1, 16'hA5A5, 3'b000}) $display("FAIL rd_response: got %b/%h/%b/%b/%b want 1/a5a5/0/0/0", r0_valid_o, r0_rdata_o, r0_rw_o, r0_err_o, r0_busy_o); else passed++;
        total++; if ({r1_valid_o, r1_rdata_o, r1_rw_o, r1_err_o, r1_busy_o} !== '0) $display("FAIL rd_r1_quiet: got %b/%h want 0/0000", r1_valid_o, r1_rdata_o); else passed++;
        tick();
        total++; if (r0_valid_o !== 1'b0) $display("FAIL rd_response_pulse: got %b want 0", r0_valid_o); else passed++;
    endtask

    task automatic test_simultaneous();
        reset_dut();
        set_req(0, 16'h0001, 16'h0000, 1'b0);
        set_req(1, 16'h0002, 16'h0000, 1'b0);
        strobe();
        total++; if ({r0_busy_o, r1_busy_o} !== 2'b11) $display("FAIL sim_capture: got %b want 11", {r0_busy_o, r1_busy_o}); else passed++;
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0001}) $display("FAIL sim_first_grant: got %b/%h want 1/0001", valid_o, addr_o); else passed++;
        tick();
        respond(16'h1111, 1'b0);
        total++; if ({r0_valid_o, r0_rdata_o, r1_valid_o, valid_o} !== {1'b1, 16'h1111, 2'b00}) $display("FAIL sim_r0_resp: got %b/%h/%b/%b want 1/1111/0/0", r0_valid_o, r0_rdata_o, r1_valid_o, valid_o); else passed++;
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0002}) $display("FAIL sim_second_grant: got %b/%h want 1/0002", valid_o, addr_o); else passed++;
        respond(16'h2222, 1'b0);
        total++; if ({r1_valid_o, r1_rdata_o, r0_valid_o} !== {1'b1, 16'h2222, 1'b0}) $display("FAIL sim_r1_resp: got %b/%h/%b want 1/2222/0", r1_valid_o, r1_rdata_o, r0_valid_o); else passed++;
        // r0 alone completes last, so the next tie goes to r1.
        set_req(0, 16'h0007, 16'h0000, 1'b0);
        strobe();
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0007}) $display("FAIL sim_solo_grant: got %b/%h want 1/0007", valid_o, addr_o); else passed++;
        respond(16'h0777, 1'b0);
        set_req(0, 16'h0003, 16'h0000, 1'b0);
        set_req(1, 16'h0004, 16'h0000, 1'b0);
        strobe();
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0004}) $display("FAIL sim_tie_r1_first: got %b/%h want 1/0004", valid_o, addr_o); else passed++;
        respond(16'h4444, 1'b0);
        total++; if ({r1_valid_o, r1_rdata_o} !== {1'b1, 16'h4444}) $display("FAIL sim_tie_r1_resp: got %b/%h want 1/4444", r1_valid_o, r1_rdata_o); else passed++;
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0003}) $display("FAIL sim_tie_r0_next: got %b/%h want 1/0003", valid_o, addr_o); else passed++;
        respond(16'h3333, 1'b0);
        total++; if ({r0_valid_o, r0_rdata_o} !== {1'b1, 16'h3333}) $display("FAIL sim_tie_r0_resp: got %b/%h want 1/3333", r0_valid_o, r0_rdata_o); else passed++;
    endtask

    task automatic test_write_drop();
        int issues;
        set_req(1, 16'h0006, 16'h00FF, 1'b1);
        strobe();
        total++; if (r1_busy_o !== 1'b1) $display("FAIL wr_busy: got %b want 1", r1_busy_o); else passed++;
        tick();
        total++; if ({valid_o, rw_o, wdata_o, addr_o} !== {2'b11, 16'h00FF, 16'h0006}) $display("FAIL wr_issue: got %b/%b/%h/%h want 1/1/00ff/0006", valid_o, rw_o, wdata_o, addr_o); else passed++;
        set_req(1, 16'h0009, 16'hAAAA, 1'b0);
        strobe();
        // A strobe on the same edge as its own response is also dropped.
        set_req(1, 16'h000A, 16'hBBBB, 1'b0);
        respond(16'h00FF, 1'b1);
        r1_valid_i = 1'b0;
        total++; if ({r1_valid_o, r1_rw_o, r1_rdata_o, r1_err_o} !== {2'b11, 16'h00FF, 1'b0}) $display("FAIL wr_response: got %b/%b/%h/%b want 1/1/00ff/0", r1_valid_o, r1_rw_o, r1_rdata_o, r1_err_o); else passed++;
        issues = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid_o) issues++;
        end
        total++; if (issues !== 0) $display("FAIL wr_dropped_strobes: got %0d extra issues want 0", issues); else passed++;
        total++; if (r1_busy_o !== 1'b0) $display("FAIL wr_busy_clear: got %b want 0", r1_busy_o); else passed++;
    endtask

    task automatic test_timeout();
        int pulses;
        reset_dut();
        set_req(0, 16'h0010, 16'h0000, 1'b0);
        set_req(1, 16'h0011, 16'h0000, 1'b0);
        strobe();
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0010}) $display("FAIL to_issue: got %b/%h want 1/0010", valid_o, addr_o); else passed++;
        pulses = 0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            if (r0_valid_o || r1_valid_o) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL to_early: got %0d pulses want 0", pulses); else passed++;
        tick();
        total++; if ({r0_valid_o, r0_err_o, r0_rdata_o, r0_rw_o} !== {2'b11, 16'h0000, 1'b0}) $display("FAIL to_abort: got %b/%b/%h/%b want 1/1/0000/0", r0_valid_o, r0_err_o, r0_rdata_o, r0_rw_o); else passed++;
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0011}) $display("FAIL to_next_issue: got %b/%h want 1/0011", valid_o, addr_o); else passed++;
        respond(16'h3333, 1'b0);
        total++; if ({r1_valid_o, r1_err_o, r1_rdata_o} !== {2'b10, 16'h3333}) $display("FAIL to_next_resp: got %b/%b/%h want 1/0/3333", r1_valid_o, r1_err_o, r1_rdata_o); else passed++;
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (r0_valid_o || r1_valid_o || valid_o) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL to_wait_forever: got %0d pulses want 0", pulses); else passed++;
        total++; if ({r0_busy_o, r1_busy_o} !== 2'b11) $display("FAIL to_still_busy: got %b want 11", {r0_busy_o, r1_busy_o}); else passed++;
`endif
    endtask

    task automatic test_reset_mid_wait();
        reset_dut();
        set_req(0, 16'h0005, 16'h1234, 1'b0);
        strobe();
        tick();
        total++; if ({valid_o, addr_o, r0_busy_o} !== {1'b1, 16'h0005, 1'b1}) $display("FAIL rst_setup: got %b/%h/%b want 1/0005/1", valid_o, addr_o, r0_busy_o); else passed++;
        rst_n = 1'b0;
        #2;
        total++; if (all_outputs() !== '0) $display("FAIL rst_async_clear: got %h want 0", all_outputs()); else passed++;
        #1 rst_n = 1'b1;
        tick();
        respond(16'hBEEF, 1'b0);
        total++; if ({r0_valid_o, r1_valid_o, r0_rdata_o, r0_busy_o} !== '0) $display("FAIL rst_late_return: got %b/%b/%h/%b want 0/0/0000/0", r0_valid_o, r1_valid_o, r0_rdata_o, r0_busy_o); else passed++;
        set_req(0, 16'h0020, 16'h0000, 1'b0);
        strobe();
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0020}) $display("FAIL rst_next_issue: got %b/%h want 1/0020", valid_o, addr_o); else passed++;
        respond(16'h1234, 1'b0);
        total++; if ({r0_valid_o, r0_rdata_o} !== {1'b1, 16'h1234}) $display("FAIL rst_next_resp: got %b/%h want 1/1234", r0_valid_o, r0_rdata_o); else passed++;
    endtask

    task automatic test_stray_return();
        tick();
        respond(16'hDEAD, 1'b1);
        total++; if ({r0_valid_o, r1_valid_o, valid_o, r0_busy_o, r1_busy_o} !== 5'b0) $display("FAIL stray_no_pulse: got %b want 00000", {r0_valid_o, r1_valid_o, valid_o, r0_busy_o, r1_busy_o}); else passed++;
        total++; if ({r0_rdata_o, r0_rw_o} !== {16'h1234, 1'b0}) $display("FAIL stray_rdata_held: got %h/%b want 1234/0", r0_rdata_o, r0_rw_o); else passed++;
        set_req(1, 16'h0030, 16'h0000, 1'b0);
        strobe();
        tick();
        total++; if ({valid_o, addr_o} !== {1'b1, 16'h0030}) $display("FAIL stray_still_idle: got %b/%h want 1/0030", valid_o, addr_o); else passed++;
        respond(16'h5555, 1'b0);
        total++; if ({r1_valid_o, r1_rdata_o} !== {1'b1, 16'h5555}) $display("FAIL stray_next_resp: got %b/%h want 1/5555", r1_valid_o, r1_rdata_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_drop();
        test_timeout();
        test_reset_mid_wait();
        test_stray_return();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
